// File: rtl/connect4_pkg.sv
// Shared Connect-4 board constants and the column-capture FSM state encoding.
package connect4_pkg;

   localparam int unsigned NUM_COLS        = 7;
   localparam int unsigned IDX_W           = 3;
   localparam int unsigned DEBOUNCE_CYCLES = 4;
   localparam int unsigned CNT_W           = 8;

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StDebounce = 2'd1;
   localparam logic [1:0] StOffer    = 2'd2;
   localparam logic [1:0] StRelease  = 2'd3;

endpackage

// File: rtl/onehot_index_encoder.sv
// Combinational one-hot to binary index conversion with a one-hot validity flag.
module onehot_index_encoder #(
   parameter int unsigned NUM_COLS = 7,
   parameter int unsigned IDX_W    = 3
) (
   input  logic [NUM_COLS-1:0] onehot,
   output logic [IDX_W-1:0]    index,
   output logic                is_onehot
);

   logic w_seen;
   logic w_multi;

   // index is only meaningful when is_onehot is set
   always_comb begin
      w_seen  = 1'b0;
      w_multi = 1'b0;
      index   = '0;
      for (int i = 0; i < int'(NUM_COLS); i++) begin
         if (onehot[i]) begin
            w_multi = w_multi | w_seen;
            w_seen  = 1'b1;
            index   = index | IDX_W'(i);
         end
      end
   end

   assign is_onehot = w_seen & ~w_multi;

endmodule

// File: rtl/column_input_capture.sv
// Debounces the column switches and offers exactly one move (or one error pulse) per press.
module column_input_capture #(
   parameter int unsigned NUM_COLS        = connect4_pkg::NUM_COLS,
   parameter int unsigned IDX_W           = connect4_pkg::IDX_W,
   parameter int unsigned DEBOUNCE_CYCLES = connect4_pkg::DEBOUNCE_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_COLS-1:0] in_column,
   input  logic [NUM_COLS-1:0] col_full,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [IDX_W-1:0]    column_decode,
   output logic                err_multi,
   output logic                err_full
);

   import connect4_pkg::*;

   localparam logic [CNT_W-1:0] DcLim = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [1:0]          r_state;
   logic [NUM_COLS-1:0] r_sample;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_valid;
   logic [IDX_W-1:0]    r_decode;
   logic                r_err_multi;
   logic                r_err_full;

   logic [1:0]          w_state_nxt;
   logic [NUM_COLS-1:0] w_sample_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_valid_nxt;
   logic [IDX_W-1:0]    w_decode_nxt;
   logic                w_err_multi_nxt;
   logic                w_err_full_nxt;

   logic [CNT_W-1:0]    w_cnt_inc;
   logic                w_decide;
   logic [IDX_W-1:0]    w_index;
   logic                w_is_onehot;

   // At a decision the current sample always equals the value being judged.
   onehot_index_encoder #(
      .NUM_COLS (NUM_COLS),
      .IDX_W    (IDX_W)
   ) u_encoder (
      .onehot    (in_column),
      .index     (w_index),
      .is_onehot (w_is_onehot)
   );

   assign w_cnt_inc = r_cnt + CntOne;

   always_comb begin
      w_state_nxt     = r_state;
      w_sample_nxt    = r_sample;
      w_cnt_nxt       = r_cnt;
      w_valid_nxt     = r_valid;
      w_decode_nxt    = r_decode;
      w_err_multi_nxt = 1'b0;
      w_err_full_nxt  = 1'b0;
      w_decide        = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (in_column != '0) begin
               w_sample_nxt = in_column;
               w_cnt_nxt    = CntOne;
               w_state_nxt  = StDebounce;
               w_decide     = (DcLim == CntOne);
            end
         end
         StDebounce: begin
            if (in_column != r_sample) begin
               if (in_column == '0) begin
                  w_sample_nxt = '0;
                  w_cnt_nxt    = '0;
                  w_state_nxt  = StIdle;
               end else begin
                  w_sample_nxt = in_column;
                  w_cnt_nxt    = CntOne;
                  w_decide     = (DcLim == CntOne);
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
               w_decide  = (w_cnt_inc == DcLim);
            end
         end
         StOffer: begin
            if (out_ready) begin
               w_valid_nxt = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = StRelease;
            end
         end
         StRelease: begin
            // Counts consecutive idle samples; any press restarts the wait.
            if (in_column == '0) begin
               if (w_cnt_inc == DcLim) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = StIdle;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end else begin
               w_cnt_nxt = '0;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = StIdle;
         end
      endcase

      if (w_decide) begin
         w_cnt_nxt = '0;
         if (!w_is_onehot) begin
            w_err_multi_nxt = 1'b1;
            w_state_nxt     = StRelease;
         end else if ((in_column & col_full) != '0) begin
            w_err_full_nxt = 1'b1;
            w_state_nxt    = StRelease;
         end else begin
            w_decode_nxt = w_index;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = StOffer;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_sample    <= '0;
         r_cnt       <= '0;
         r_valid     <= 1'b0;
         r_decode    <= '0;
         r_err_multi <= 1'b0;
         r_err_full  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sample    <= w_sample_nxt;
         r_cnt       <= w_cnt_nxt;
         r_valid     <= w_valid_nxt;
         r_decode    <= w_decode_nxt;
         r_err_multi <= w_err_multi_nxt;
         r_err_full  <= w_err_full_nxt;
      end
   end

   assign out_valid     = r_valid;
   assign column_decode = r_decode;
   assign err_multi     = r_err_multi;
   assign err_full      = r_err_full;

endmodule
